// File: rtl/dual_memory_arb.sv
// Dual-port line/column memory with req/ready arbitration, registered read data,
// post-reset clear sweep and a port-B "new read target" toggle.
// Port A works on full lines under a column write mask; port B works on one column.
module dual_memory_arb #(
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int unsigned COL_SEL_W  = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  parameter bit          RR_ARB     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  a_req,
  output logic                  a_ready,
  input  logic [NUM_COL-1:0]    a_wmask,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_req,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [COL_SEL_W-1:0]  b_col,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [COL_WIDTH-1:0]  b_din,
  output logic [COL_WIDTH-1:0]  b_dout,
  output logic                  b_valid,
  output logic                  b_toggle
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic                    rr_b_q, rr_b_d;   // 1: B wins the next conflict
  logic                    run, grant_b;
  logic                    a_wr, a_rd, b_wr, b_rd;
  logic [NUM_COL-1:0]      col_we;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];
  logic [DATA_WIDTH-1:0]   b_line;
  logic [COL_WIDTH-1:0]    b_col_data;
  logic [ADDR_WIDTH+COL_SEL_W-1:0] b_tgt, last_tgt_q;
  logic                    last_vld_q;
  logic [DATA_WIDTH-1:0]   a_dout_q;
  logic [COL_WIDTH-1:0]    b_dout_q;
  logic                    a_valid_q, b_valid_q, b_toggle_q;

  // Sweep FSM: clear one line per cycle, then stay in RUN until reset.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + ADDR_WIDTH'(1);
        if (sweep_q == '1) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Arbitration and accept decode; ready is combinational from req.
  always_comb begin
    run     = (state_q == StRun);
    grant_b = RR_ARB ? rr_b_q : 1'b1;
    a_ready = run & a_req & ~(b_req & grant_b);
    b_ready = run & b_req & ~(a_req & ~grant_b);
    // Pointer moves only on a real conflict: the loser gets priority next time.
    rr_b_d  = (run & a_req & b_req) ? ~grant_b : rr_b_q;
    a_wr    = a_ready & (|a_wmask);
    a_rd    = a_ready & ~(|a_wmask);
    b_wr    = b_ready & b_we;
    b_rd    = b_ready & ~b_we;
  end

  // Single array write port: sweep, port A masked line, or port B single column.
  always_comb begin
    col_we  = '0;
    wr_addr = a_addr;
    wr_data = a_din;
    if (!run) begin
      col_we  = '1;
      wr_addr = sweep_q;
      wr_data = '0;
    end else if (a_wr) begin
      col_we = a_wmask;
    end else if (b_wr) begin
      wr_addr = b_addr;
      wr_data = {NUM_COL{b_din}};
      // An out-of-range column matches nothing, so the write is dropped.
      for (int k = 0; k < NUM_COL; k++) col_we[k] = (b_col == COL_SEL_W'(k));
    end
  end

  // Array storage; no reset, contents are cleared by the sweep.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_COL; k++) begin
      if (col_we[k]) mem_q[wr_addr][k*COL_WIDTH +: COL_WIDTH] <= wr_data[k*COL_WIDTH +: COL_WIDTH];
    end
  end

  // Port-B column select; out-of-range columns read as zero.
  always_comb begin
    b_line     = mem_q[b_addr];
    b_col_data = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      if (b_col == COL_SEL_W'(k)) b_col_data = b_line[k*COL_WIDTH +: COL_WIDTH];
    end
    b_tgt = {b_addr, b_col};
  end

  // Control state, registered read data, valid strobes and B-target tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      sweep_q    <= '0;
      rr_b_q     <= 1'b1;
      a_dout_q   <= '0;
      b_dout_q   <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_toggle_q <= 1'b1;
      last_tgt_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      rr_b_q    <= rr_b_d;
      a_valid_q <= a_rd;
      b_valid_q <= b_rd;
      if (a_rd) a_dout_q <= mem_q[a_addr];
      if (b_rd) begin
        b_dout_q <= b_col_data;
        if (!last_vld_q || (b_tgt != last_tgt_q)) begin
          b_toggle_q <= ~b_toggle_q;
          last_tgt_q <= b_tgt;
          last_vld_q <= 1'b1;
        end
      end
    end
  end

  assign init_done = (state_q == StRun);
  assign a_dout    = a_dout_q;
  assign a_valid   = a_valid_q;
  assign b_dout    = b_dout_q;
  assign b_valid   = b_valid_q;
  assign b_toggle  = b_toggle_q;

endmodule

// File: tb/tb_dual_memory_arb.sv
// Directed bench for dual_memory_arb: one fixed-priority and one round-robin instance
// share all inputs; each task drives a scenario and checks against hand-computed values.
module tb_dual_memory_arb;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         a_req = 1'b0;
  logic [3:0]   a_wmask = '0;
  logic [5:0]   a_addr = '0;
  logic [127:0] a_din = '0;
  logic         b_req = 1'b0;
  logic         b_we = 1'b0;
  logic [1:0]   b_col = '0;
  logic [5:0]   b_addr = '0;
  logic [31:0]  b_din = '0;

  logic         init_done_0, a_ready_0, a_valid_0, b_ready_0, b_valid_0, b_toggle_0;
  logic [127:0] a_dout_0;
  logic [31:0]  b_dout_0;
  logic         init_done_1, a_ready_1, a_valid_1, b_ready_1, b_valid_1, b_toggle_1;
  logic [127:0] a_dout_1;
  logic [31:0]  b_dout_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_memory_arb #(.RR_ARB(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_0),
    .a_req(a_req), .a_ready(a_ready_0), .a_wmask(a_wmask), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout_0), .a_valid(a_valid_0),
    .b_req(b_req), .b_ready(b_ready_0), .b_we(b_we), .b_col(b_col), .b_addr(b_addr),
    .b_din(b_din), .b_dout(b_dout_0), .b_valid(b_valid_0), .b_toggle(b_toggle_0)
  );

  dual_memory_arb #(.RR_ARB(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_done(init_done_1),
    .a_req(a_req), .a_ready(a_ready_1), .a_wmask(a_wmask), .a_addr(a_addr), .a_din(a_din),
    .a_dout(a_dout_1), .a_valid(a_valid_1),
    .b_req(b_req), .b_ready(b_ready_1), .b_we(b_we), .b_col(b_col), .b_addr(b_addr),
    .b_din(b_din), .b_dout(b_dout_1), .b_valid(b_valid_1), .b_toggle(b_toggle_1)
  );

  task automatic test_reset;
    #2 rst_n = 1'b0;
    a_req = 1'b1;
    b_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({init_done_0, a_ready_0, b_ready_0, a_valid_0, b_valid_0, b_toggle_0} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl0: got %b expected 000001",
               {init_done_0, a_ready_0, b_ready_0, a_valid_0, b_valid_0, b_toggle_0});
    end
    checks++;
    if ({init_done_1, a_ready_1, b_ready_1, a_valid_1, b_valid_1, b_toggle_1} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl1: got %b expected 000001",
               {init_done_1, a_ready_1, b_ready_1, a_valid_1, b_valid_1, b_toggle_1});
    end
    checks++;
    if (a_dout_0 !== '0 || b_dout_0 !== '0) begin
      errors++;
      $display("FAIL reset_dout: got a=%h b=%h expected 0", a_dout_0, b_dout_0);
    end
    rst_n = 1'b1;
    // Requests held high through the sweep must never be accepted.
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      checks++;
      if (k < 64) begin
        if ({init_done_0, a_ready_0, b_ready_0, init_done_1} !== 4'b0000) begin
          errors++;
          $display("FAIL sweep_busy k=%0d: got %b expected 0000", k,
                   {init_done_0, a_ready_0, b_ready_0, init_done_1});
        end
      end else begin
        if ({init_done_0, init_done_1} !== 2'b11) begin
          errors++;
          $display("FAIL sweep_done: got %b expected 11", {init_done_0, init_done_1});
        end
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic test_sweep_clear;
    a_req = 1'b1; a_wmask = 4'b0000; a_addr = 6'd40;
    #1;
    checks++;
    if (a_ready_0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_ready: got %b expected 1", a_ready_0);
    end
    @(negedge clk);
    a_req = 1'b0;
    checks++;
    if (a_valid_0 !== 1'b1 || a_dout_0 !== '0) begin
      errors++;
      $display("FAIL clear_read: got valid=%b dout=%h expected valid=1 dout=0", a_valid_0, a_dout_0);
    end
  endtask

  task automatic test_a_mask;
    logic [127:0] exp1, exp2;
    exp1 = {32'h0000DDDD, 32'h0, 32'h0000BBBB, 32'h0};
    exp2 = {32'h0000DDDD, 32'h00002222, 32'h0000BBBB, 32'h00004444};
    @(negedge clk);
    a_req = 1'b1; a_wmask = 4'b1010; a_addr = 6'd5;
    a_din = {32'h0000DDDD, 32'h0000CCCC, 32'h0000BBBB, 32'h0000AAAA};
    @(negedge clk);
    a_wmask = 4'b0000;
    checks++;
    if (a_valid_0 !== 1'b0) begin
      errors++;
      $display("FAIL a_write_novalid: got %b expected 0", a_valid_0);
    end
    @(negedge clk);
    a_req = 1'b0;
    checks++;
    if (a_valid_0 !== 1'b1 || a_dout_0 !== exp1) begin
      errors++;
      $display("FAIL a_mask1010: got valid=%b dout=%h expected 1 %h", a_valid_0, a_dout_0, exp1);
    end
    @(negedge clk);
    checks++;
    if (a_valid_0 !== 1'b0 || a_dout_0 !== exp1) begin
      errors++;
      $display("FAIL a_hold: got valid=%b dout=%h expected 0 %h", a_valid_0, a_dout_0, exp1);
    end
    a_req = 1'b1; a_wmask = 4'b0101;
    a_din = {32'h00001111, 32'h00002222, 32'h00003333, 32'h00004444};
    @(negedge clk);
    a_wmask = 4'b0000;
    @(negedge clk);
    a_req = 1'b0;
    checks++;
    if (a_valid_0 !== 1'b1 || a_dout_0 !== exp2) begin
      errors++;
      $display("FAIL a_mask0101: got valid=%b dout=%h expected 1 %h", a_valid_0, a_dout_0, exp2);
    end
  endtask

  task automatic test_b_toggle;
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 6'd3; b_col = 2'd2; b_din = 32'h1234_5678;
    #1;
    checks++;
    if (b_ready_0 !== 1'b1) begin
      errors++;
      $display("FAIL b_ready: got %b expected 1", b_ready_0);
    end
    @(negedge clk);
    b_we = 1'b0;
    checks++;
    if (b_toggle_0 !== 1'b1 || b_valid_0 !== 1'b0) begin
      errors++;
      $display("FAIL b_write_notoggle: got tog=%b valid=%b expected 1 0", b_toggle_0, b_valid_0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) b_col = 2'd1;
      checks++;
      if (b_valid_0 !== 1'b1 || b_dout_0 !== 32'h1234_5678 || b_toggle_0 !== 1'b0) begin
        errors++;
        $display("FAIL b_read_same%0d: got v=%b d=%h t=%b expected 1 12345678 0", i, b_valid_0,
                 b_dout_0, b_toggle_0);
      end
    end
    @(negedge clk);
    b_req = 1'b0;
    checks++;
    if (b_valid_0 !== 1'b1 || b_dout_0 !== 32'h0 || b_toggle_0 !== 1'b1) begin
      errors++;
      $display("FAIL b_read_col1: got v=%b d=%h t=%b expected 1 00000000 1", b_valid_0, b_dout_0,
               b_toggle_0);
    end
    a_req = 1'b1; a_wmask = 4'b0000; a_addr = 6'd3;
    @(negedge clk);
    a_req = 1'b0;
    checks++;
    if (b_valid_0 !== 1'b0) begin
      errors++;
      $display("FAIL b_valid_pulse: got %b expected 0", b_valid_0);
    end
    @(negedge clk);
    checks++;
    if (a_dout_0 !== {32'h0, 32'h1234_5678, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL b_single_col: got %h expected 0..12345678..0", a_dout_0);
    end
  endtask

  task automatic test_write_then_read;
    @(negedge clk);
    a_req = 1'b1; a_wmask = 4'b1111; a_addr = 6'd9;
    a_din = {32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001, 32'hCAFE_F00D};
    @(negedge clk);
    a_req = 1'b0; a_wmask = 4'b0000;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd9; b_col = 2'd0;
    #1;
    checks++;
    if (b_ready_0 !== 1'b1) begin
      errors++;
      $display("FAIL wtr_ready: got %b expected 1", b_ready_0);
    end
    @(negedge clk);
    b_req = 1'b0;
    checks++;
    if (b_valid_0 !== 1'b1 || b_dout_0 !== 32'hCAFE_F00D || b_toggle_0 !== 1'b0) begin
      errors++;
      $display("FAIL wtr_read: got v=%b d=%h t=%b expected 1 cafef00d 0", b_valid_0, b_dout_0,
               b_toggle_0);
    end
  endtask

  task automatic test_conflict;
    @(negedge clk);
    a_req = 1'b1; a_wmask = 4'b0000; a_addr = 6'd5;
    b_req = 1'b1; b_we = 1'b0; b_addr = 6'd9; b_col = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({a_ready_0, b_ready_0} !== 2'b01) begin
        errors++;
        $display("FAIL fixed_grant%0d: got a/b=%b expected 01", i, {a_ready_0, b_ready_0});
      end
      checks++;
      if ({a_ready_1, b_ready_1} !== ((i == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant%0d: got a/b=%b expected %b", i, {a_ready_1, b_ready_1},
                 (i == 1) ? 2'b10 : 2'b01);
      end
      @(negedge clk);
      checks++;
      if ({a_valid_0, b_valid_0, a_valid_1} !== {2'b01, (i == 1)}) begin
        errors++;
        $display("FAIL conflict_valid%0d: got %b expected %b", i,
                 {a_valid_0, b_valid_0, a_valid_1}, {2'b01, (i == 1)});
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    checks++;
    if (a_dout_1 !== {32'h0000DDDD, 32'h00002222, 32'h0000BBBB, 32'h00004444}) begin
      errors++;
      $display("FAIL rr_a_data: got %h expected dddd/2222/bbbb/4444", a_dout_1);
    end
  endtask

  task automatic test_reset_mid_sweep;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_dout_1 !== '0 || b_dout_0 !== '0 || b_toggle_0 !== 1'b1 || b_toggle_1 !== 1'b1 ||
        init_done_0 !== 1'b0) begin
      errors++;
      $display("FAIL run_reset: got a1=%h b0=%h t=%b%b id=%b expected 0 0 11 0", a_dout_1,
               b_dout_0, b_toggle_0, b_toggle_1, init_done_0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) @(negedge clk);
    a_req = 1'b1; a_wmask = 4'b0000; a_addr = 6'd5;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({init_done_0, a_ready_0, a_valid_0, b_valid_0, b_toggle_0} !== 5'b00001) begin
      errors++;
      $display("FAIL sweep_reset: got %b expected 00001",
               {init_done_0, a_ready_0, a_valid_0, b_valid_0, b_toggle_0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      checks++;
      if (init_done_0 !== (k == 64) || init_done_1 !== (k == 64)) begin
        errors++;
        $display("FAIL resweep k=%0d: got %b%b expected %b", k, init_done_0, init_done_1, (k == 64));
      end
    end
    @(negedge clk);
    a_req = 1'b0;
    checks++;
    if (a_valid_0 !== 1'b1 || a_dout_0 !== '0) begin
      errors++;
      $display("FAIL resweep_clear: got v=%b d=%h expected 1 0", a_valid_0, a_dout_0);
    end
  endtask

  initial begin
    test_reset();
    test_sweep_clear();
    test_a_mask();
    test_b_toggle();
    test_write_then_read();
    test_conflict();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_memory_arb.md
Name: dual_memory_arb

Overview:
- Parametrised successor to the UHCI descriptor/frame dual-port memory.
- Port A (UHCI engine) accesses full lines with an arbitrary column write mask. Port B (AXI slave side) accesses one column, selected by index.
- Adds req/ready arbitration (fixed or round-robin), registered read data with a valid strobe, a post-reset clear sweep, and a generalised new-access toggle on port B.

Parameters:
- NUM_COL, 4, columns per line
- COL_WIDTH, 32, bits per column
- ADDR_WIDTH, 6, line address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, NUM_COL*COL_WIDTH, line width
- COL_SEL_W, $clog2(NUM_COL), width of port-B column index
- RR_ARB, 0, 0 = port B fixed priority; 1 = round-robin on conflict

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- init_done  out  1  high once the clear sweep is complete
- a_req  in  1  port A request
- a_ready  out  1  port A request accepted this cycle
- a_wmask  in  NUM_COL  per-column write mask; all-zero = read
- a_addr  in  ADDR_WIDTH  line address
- a_din  in  DATA_WIDTH  write data; column k uses bits [k*COL_WIDTH +: COL_WIDTH]
- a_dout  out  DATA_WIDTH  read data
- a_valid  out  1  a_dout valid pulse
- b_req  in  1  port B request
- b_ready  out  1  port B request accepted
- b_we  in  1  1 = write, 0 = read
- b_col  in  COL_SEL_W  column index
- b_addr  in  ADDR_WIDTH  line address
- b_din  in  COL_WIDTH  write data
- b_dout  out  COL_WIDTH  read data
- b_valid  out  1  b_dout valid pulse
- b_toggle  out  1  flips on each new port-B read target

Behaviour:
- Reset (async, rst_n=0):
  - a_dout=0, b_dout=0, a_valid=0, b_valid=0, b_toggle=1, init_done=0.
  - Sweep counter=0, round-robin pointer=B, last B target cleared to "none".
- FSM:
  - INIT: writes 0 to line counter each cycle, incrementing. After line 2**ADDR_WIDTH-1 is written, go to RUN and set init_done=1 the next cycle. Sweep takes exactly 2**ADDR_WIDTH cycles after reset release.
  - RUN: terminal state. Only rst_n returns the FSM to INIT. Reset asserted mid-sweep or mid-access restarts the sweep from line 0.
- Ready generation:
  - Both ready outputs are low in INIT.
  - In RUN, ready is combinational: a_ready = a_req & ~(b_req & grant_B); b_ready = b_req & ~(a_req & ~grant_B).
  - RR_ARB=0: grant_B=1 on conflict.
  - RR_ARB=1: on conflict, grant goes to the port that lost the previous conflict; pointer updates only on conflicts.
  - A non-granted requester must hold req and all inputs stable until ready.
- Accepted write (req & ready at posedge):
  - Port A: updates only columns with a_wmask=1. Any mask pattern is legal, not only one-hot or all-ones.
  - Port B: updates column b_col only.
  - b_col >= NUM_COL: write is ignored but still accepted.
- Accepted read:
  - Data registered with 1-cycle latency; valid pulses high for exactly one cycle.
  - dout holds its last value otherwise (no forced zero).
  - b_col out of range returns 0.
- Write-then-read: a write accepted in cycle N is visible to any read accepted in cycle N+1 or later, from either port.
- Only one port is accepted per cycle, so no same-cycle collision on the array.
- b_toggle:
  - On an accepted port-B read whose {b_addr,b_col} differs from the last accepted B read target, b_toggle inverts in the same edge as b_dout loads, and the target is recorded.
  - Repeated reads of the same target leave it unchanged.
  - Writes never affect it.
  - The first read after reset always toggles.
- No combinational path from req to dout.
- Memory contents are not reset by logic other than the sweep.

Test Plan:
- Reset, then release rst_n → ready low and init_done=0 for 64 cycles; init_done=1 at cycle 65; a port-A read of any line returns 0.
- A writes addr 5, mask 4'b1010, din={32'hDDDD,32'hCCCC,32'hBBBB,32'hAAAA}, then reads addr 5 → a_dout={32'hDDDD,32'h0,32'hBBBB,32'h0} with a_valid one cycle after acceptance.
- B writes addr 3 col 2 = 32'h1234_5678, then reads it twice, then reads addr 3 col 1 → b_dout=32'h12345678 both times, b_toggle 1→0 then held, then 0→1 on the col-1 read.
- RR_ARB=0, A and B both requesting for 3 cycles → B accepted each cycle, a_ready=0 throughout. RR_ARB=1, same stimulus → grants alternate B, A, B.
- Assert rst_n low at sweep line 20 → outputs return to reset values; sweep restarts at line 0 and init_done rises 64 cycles after release.
- A write to addr 9 accepted at cycle N, B read of addr 9 col 0 accepted at N+1 → b_dout equals the new column-0 data.
